// File: rtl/sbi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sbi_pkg
// Description : Shared constants, state encoding and the 32-column
//               permutation table for the sub-block interleaver.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sbi_pkg;

   localparam int unsigned C       = 32;
   localparam int unsigned K_SMALL = 1056;
   localparam int unsigned K_LARGE = 6144;
   localparam int unsigned R_SMALL = 33;
   localparam int unsigned R_LARGE = 192;

   localparam int unsigned AW = 13;   // buffer address width (0..6143)
   localparam int unsigned CW = 5;    // column index width
   localparam int unsigned RW = 8;    // row index width (0..191)
   localparam int unsigned DW = 3;    // {d2,d1,d0}

   // Terminal counts, pre-sized so the comparisons in the datapath match widths.
   localparam logic [AW-1:0] KLAST_SMALL = AW'(K_SMALL - 1);
   localparam logic [AW-1:0] KLAST_LARGE = AW'(K_LARGE - 1);
   localparam logic [RW-1:0] RLAST_SMALL = RW'(R_SMALL - 1);
   localparam logic [RW-1:0] RLAST_LARGE = RW'(R_LARGE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Inter-column permutation: column j of the output is column perm(j)
   // of the row-wise written matrix.
   function automatic logic [CW-1:0] perm(input logic [CW-1:0] j);
      logic [CW-1:0] p;
      p = '0;
      case (j)
         5'd0:  p = 5'd1;
         5'd1:  p = 5'd17;
         5'd2:  p = 5'd9;
         5'd3:  p = 5'd25;
         5'd4:  p = 5'd5;
         5'd5:  p = 5'd21;
         5'd6:  p = 5'd13;
         5'd7:  p = 5'd29;
         5'd8:  p = 5'd3;
         5'd9:  p = 5'd19;
         5'd10: p = 5'd11;
         5'd11: p = 5'd27;
         5'd12: p = 5'd7;
         5'd13: p = 5'd23;
         5'd14: p = 5'd15;
         5'd15: p = 5'd31;
         5'd16: p = 5'd0;
         5'd17: p = 5'd16;
         5'd18: p = 5'd8;
         5'd19: p = 5'd24;
         5'd20: p = 5'd4;
         5'd21: p = 5'd20;
         5'd22: p = 5'd12;
         5'd23: p = 5'd28;
         5'd24: p = 5'd2;
         5'd25: p = 5'd18;
         5'd26: p = 5'd10;
         5'd27: p = 5'd26;
         5'd28: p = 5'd6;
         5'd29: p = 5'd22;
         5'd30: p = 5'd14;
         5'd31: p = 5'd30;
         default: p = '0;
      endcase
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sbi_buf_ram.sv
`default_nettype none
// ============================================================================
// Module      : sbi_buf_ram
// Description : 8192 x 3 simple dual-port RAM, one write port, one
//               synchronous read port (1-cycle latency, output holds while
//               re_i is low).
// Ports       : clk               - clock
//               we_i/waddr_i/wdata_i - write port
//               re_i/raddr_i      - read enable / address
//               rdata_o           - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sbi_buf_ram
   import sbi_pkg::*;
(
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];

   // No reset on the array or read register so the tools map this onto
   // block RAM. Load and drain never overlap, so read-during-write
   // behaviour is irrelevant.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule
`default_nettype wire

// File: rtl/subblock_interleaver.sv
`default_nettype none
// ============================================================================
// Module      : subblock_interleaver
// Description : 32-column sub-block interleaver for the three coded streams
//               of the convolutional encoder. A block (K=1056 or 6144) is
//               written row-wise, then read column-wise in permuted column
//               order.
// Ports       : clk, reset          - clock, async active-high reset
//               blk_size            - 0: K=1056, 1: K=6144 (start beat only)
//               d_in/d_valid/d_first/in_ready - input beat stream
//               out_data/out_valid/out_last/out_ready - output beat stream
//               busy                - high in LOAD or DRAIN
// Revision    : 1.0 - initial release
// ============================================================================
module subblock_interleaver
   import sbi_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          blk_size,
   input  logic [DW-1:0] d_in,
   input  logic          d_valid,
   input  logic          d_first,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   output logic          out_last,
   input  logic          out_ready,
   output logic          busy
);

   state_t        state_q, state_d;
   logic          ksel_q;
   logic [AW-1:0] wr_cnt_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic          rd_done_q;
   logic          pend_q;          // RAM read register holds a live beat
   logic          pend_last_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic [DW-1:0] out_data_q;
   logic          busy_q;

   logic          w_accept;
   logic          w_adv;
   logic          w_issue;
   logic          w_issue_last;
   logic          w_done;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [AW-1:0] w_raddr;
   logic [DW-1:0] w_rdata;
   logic [AW-1:0] w_k_last;
   logic [RW-1:0] w_r_last;

   assign w_k_last = ksel_q ? KLAST_LARGE : KLAST_SMALL;
   assign w_r_last = ksel_q ? RLAST_LARGE : RLAST_SMALL;

   assign w_accept = d_valid && in_ready_q;
   // in_ready is low in DRAIN, so any accepted beat is either a block start
   // or a LOAD beat; IDLE beats without d_first are simply not written.
   assign w_we     = w_accept && (d_first || (state_q == LOAD));
   assign w_waddr  = d_first ? '0 : wr_cnt_q;

   // The RAM read register and the output register form a two-stage
   // pipeline that moves as one: both stall while the output is held.
   assign w_adv        = !out_valid_q || out_ready;
   assign w_issue      = (state_q == DRAIN) && w_adv && !rd_done_q;
   assign w_issue_last = (col_q == CW'(C - 1)) && (row_q == w_r_last);
   assign w_raddr      = {row_q, perm(col_q)};
   assign w_done       = out_valid_q && out_last_q && out_ready;

   sbi_buf_ram u_buf (
      .clk     (clk),
      .we_i    (w_we),
      .waddr_i (w_waddr),
      .wdata_i (d_in),
      .re_i    (w_issue),
      .raddr_i (w_raddr),
      .rdata_o (w_rdata)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (w_accept && d_first) state_d = LOAD;
         LOAD:    if (w_accept && !d_first && (wr_cnt_q == w_k_last)) state_d = DRAIN;
         DRAIN:   if (w_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ksel_q      <= 1'b0;
         wr_cnt_q    <= '0;
         col_q       <= '0;
         row_q       <= '0;
         rd_done_q   <= 1'b0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != DRAIN);
         busy_q     <= (state_d != IDLE);

         // Write side: a start beat (also mid-block) restarts at address 0.
         if (w_accept && d_first) begin
            ksel_q   <= blk_size;
            wr_cnt_q <= AW'(1);
         end else if (w_accept && (state_q == LOAD)) begin
            wr_cnt_q <= (wr_cnt_q == w_k_last) ? '0 : (wr_cnt_q + AW'(1));
         end

         // Read side: rows are the inner loop, columns the outer loop.
         // Both counters wrap back to zero after the final address.
         if (w_issue) begin
            if (w_issue_last) begin
               rd_done_q <= 1'b1;
            end
            if (row_q == w_r_last) begin
               row_q <= '0;
               col_q <= col_q + CW'(1);
            end else begin
               row_q <= row_q + RW'(1);
            end
         end
         if (w_done) begin
            rd_done_q <= 1'b0;
         end

         if (w_adv) begin
            pend_q      <= w_issue;
            pend_last_q <= w_issue && w_issue_last;
         end

         if (w_done) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end else if (w_adv) begin
            out_valid_q <= pend_q;
            out_last_q  <= pend_last_q;
            if (pend_q) begin
               out_data_q <= w_rdata;
            end
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_subblock_interleaver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_subblock_interleaver
// Description : Self-checking bench for subblock_interleaver. Expected output
//               order is computed directly from the column-wise read rule
//               over a copy of the source block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subblock_interleaver;

   logic       clk = 1'b0;
   logic       reset;
   logic       blk_size;
   logic [2:0] d_in;
   logic       d_valid;
   logic       d_first;
   logic       in_ready;
   logic [2:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic       busy;

   always #5 clk = ~clk;

   subblock_interleaver dut (
      .clk       (clk),
      .reset     (reset),
      .blk_size  (blk_size),
      .d_in      (d_in),
      .d_valid   (d_valid),
      .d_first   (d_first),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   int checks   = 0;
   int failures = 0;

   int perm_tbl [32] = '{1,17,9,25,5,21,13,29,3,19,11,27,7,23,15,31,
                         0,16,8,24,4,20,12,28,2,18,10,26,6,22,14,30};

   logic [2:0] src [6144];
   logic [2:0] got_d [$];
   bit         got_l [$];
   int         lat;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {last, data} of collected output beat i, X if that beat never came.
   function automatic logic [3:0] beat(input int i);
      if (i < got_d.size()) return {got_l[i], got_d[i]};
      return 4'bxxxx;
   endfunction

   // Sends n beats; d_first on beat 0 with blk_size=ksel, the opposite size
   // on all other beats (it must be ignored there).
   task automatic send_block(input int n, input bit ksel, input bit pattern, input string tag);
      int nready;
      logic [2:0] v;
      nready = 0;
      for (int i = 0; i < n; i++) begin
         v        = pattern ? i[2:0] : 3'($urandom);
         d_valid  = 1'b1;
         d_first  = (i == 0);
         blk_size = (i == 0) ? ksel : ~ksel;
         d_in     = v;
         if (!in_ready) nready++;
         src[i] = v;
         tick();
      end
      d_valid = 1'b0;
      d_first = 1'b0;
      check({tag, "_in_ready_load"}, nready, 0);
   endtask

   // Collects output beats until out_last is consumed (or stop_at beats).
   task automatic drain(input int k, input bit rnd_ready, input int stop_at,
                        input string tag, output int latency);
      int budget, cyc, stab, ir;
      bit have_hold, done;
      logic [2:0] hold_d;
      logic       hold_l;
      got_d.delete();
      got_l.delete();
      budget = 4 * k + 50;
      cyc = 0; stab = 0; ir = 0; have_hold = 0; done = 0;
      latency = -1;
      while (!done && cyc < budget) begin
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (have_hold && (!out_valid || out_data !== hold_d || out_last !== hold_l)) stab++;
         if (out_valid && latency < 0) latency = cyc;
         if (in_ready) ir++;
         have_hold = out_valid && !out_ready;
         hold_d    = out_data;
         hold_l    = out_last;
         if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            if (out_last || got_d.size() == stop_at) done = 1;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b1;
      check({tag, "_drain_done"}, done, 1);
      check({tag, "_stall_hold"}, stab, 0);
      check({tag, "_in_ready_drain"}, ir, 0);
   endtask

   // Compares collected beats with the column-wise read of src.
   task automatic score(input int k, input string tag);
      int rows, idx, bad, lastc;
      rows = k / 32; idx = 0; bad = 0; lastc = 0;
      for (int j = 0; j < 32; j++) begin
         for (int r = 0; r < rows; r++) begin
            if (idx < got_d.size()) begin
               if (got_d[idx] !== src[r * 32 + perm_tbl[j]]) bad++;
               if (got_l[idx] !== (idx == k - 1)) bad++;
               if (got_l[idx]) lastc++;
            end
            idx++;
         end
      end
      check({tag, "_count"}, got_d.size(), k);
      check({tag, "_data"}, bad, 0);
      check({tag, "_last_count"}, lastc, 1);
      check({tag, "_post_valid"}, out_valid, 0);
      check({tag, "_post_busy"}, busy, 0);
      check({tag, "_post_in_ready"}, in_ready, 1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idle_bad;
      reset = 1'b1; d_valid = 1'b0; d_first = 1'b0; d_in = '0;
      blk_size = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  in_ready,  0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last",  out_last,  0);
      check("rst_out_data",  out_data,  0);
      check("rst_busy",      busy,      0);
      reset = 1'b0;
      tick();
      check("rst_rel_in_ready", in_ready, 1);

      // 1: K=1056, d_in = i[2:0], out_ready high
      send_block(1056, 1'b0, 1'b1, "t1");
      check("t1_busy_drain", busy, 1);
      drain(1056, 1'b0, 0, "t1", lat);
      check("t1_latency", lat, 2);
      check("t1_beat0",    beat(0),    4'b0001);
      check("t1_beat1",    beat(1),    4'b0001);
      check("t1_beat33",   beat(33),   4'b0001);
      check("t1_beat1055", beat(1055), 4'b1110);
      score(1056, "t1");

      // 2: K=6144 random, started back-to-back after the previous block
      send_block(6144, 1'b1, 1'b0, "t2");
      drain(6144, 1'b0, 0, "t2", lat);
      check("t2_beat192",  beat(192),  {1'b0, src[17]});
      check("t2_beat6143", beat(6143), {1'b1, src[6142]});
      score(6144, "t2");

      // 3: K=1056 with random backpressure
      send_block(1056, 1'b0, 1'b0, "t3");
      drain(1056, 1'b1, 0, "t3", lat);
      check("t3_latency", lat, 2);
      score(1056, "t3");

      // 4: K=6144 block restarted at beat 500 as K=1056
      send_block(500, 1'b1, 1'b0, "t4a");
      send_block(1056, 1'b0, 1'b0, "t4");
      drain(1056, 1'b0, 0, "t4", lat);
      score(1056, "t4");

      // 5: reset in the middle of draining
      send_block(1056, 1'b0, 1'b0, "t5a");
      drain(1056, 1'b0, 300, "t5a", lat);
      check("t5_partial", got_d.size(), 300);
      reset = 1'b1;
      #1;
      check("t5_rst_out_valid", out_valid, 0);
      check("t5_rst_in_ready",  in_ready,  0);
      check("t5_rst_busy",      busy,      0);
      check("t5_rst_out_last",  out_last,  0);
      check("t5_rst_out_data",  out_data,  0);
      tick();
      check("t5_rst_hold_in_ready", in_ready, 0);
      reset = 1'b0;
      tick();
      check("t5_rel_in_ready", in_ready, 1);
      send_block(1056, 1'b0, 1'b0, "t5");
      drain(1056, 1'b1, 0, "t5", lat);
      score(1056, "t5");

      // 6: IDLE beats without d_first are dropped
      idle_bad = 0;
      for (int i = 0; i < 10; i++) begin
         d_valid = 1'b1;
         d_first = 1'b0;
         d_in    = 3'($urandom);
         tick();
         if (busy || out_valid || !in_ready) idle_bad++;
      end
      d_valid = 1'b0;
      check("t6_idle_ignored", idle_bad, 0);
      send_block(1056, 1'b0, 1'b0, "t6");
      drain(1056, 1'b0, 0, "t6", lat);
      score(1056, "t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
